// File: rtl/regfile_param.sv
// Parametrised register file with N combinational read ports, one write port,
// optional zero register, optional write-to-read bypass and a clear sweeper.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clr_req     - start a full zeroing sweep (ignored while one is running)
//   ready       - 1 in normal operation, 0 while the sweep runs
//   we3/wa3/wd3 - write enable, address, data
//   ra          - packed read addresses, port k at [k*AW +: AW]
//   rd          - packed read data,      port k at [k*XLEN +: XLEN]
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we3,
  input  logic [AW-1:0]     wa3,
  input  logic [XLEN-1:0]   wd3,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd
);

  if (NREGS < 2) begin : g_bad_depth
    $error("regfile_param: NREGS must be at least 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_param: NRD must be 1..4");
  end

  // Address space is fully populated when NREGS is a power of two; the
  // range checks then collapse to constants and are left out entirely.
  localparam bit FULL = (NREGS == (1 << AW));
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  logic [XLEN-1:0] mem [NREGS];

  logic            wa_ok;
  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  if (FULL) begin : g_wa_full
    assign wa_ok = 1'b1;
  end else begin : g_wa_chk
    assign wa_ok = ({1'b0, wa3} < (AW+1)'(NREGS));
  end

  // A user write is real only in range and not aimed at a hardwired zero.
  assign wr_ok = we3 & wa_ok
               & ~((ZERO_REG != 0) && (wa3 == '0));

  assign ready = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = '0;
    unique case (state_q)
      CLEAR: begin
        // Sweep owns the write port; user writes and clr_req are dropped.
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = '0;
        if (ptr_q == LAST) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      RUN: begin
        if (wr_ok) begin
          mem_we = 1'b1;
          mem_wa = wa3;
          mem_wd = wd3;
        end
        // The write above still lands; the sweep zeroes it later.
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            in_rng;
    logic [XLEN-1:0] val;

    assign a = ra[k*AW +: AW];

    if (FULL) begin : g_full
      assign in_rng = 1'b1;
    end else begin : g_chk
      assign in_rng = ({1'b0, a} < (AW+1)'(NREGS));
    end

    always_comb begin
      val = '0;
      if (state_q == CLEAR) begin
        val = '0;
      end else if (!in_rng) begin
        val = '0;
      end else if ((ZERO_REG != 0) && (a == '0)) begin
        val = '0;
      end else if ((BYPASS != 0) && we3 && (wa3 == a)) begin
        val = wd3;
      end else begin
        val = mem[a];
      end
    end

    assign rd[k*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: three instances cover the default
// config, no-bypass/no-zero-reg, and an odd 20-entry 3-port config.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [9:0]  ra_ab;
  logic [14:0] ra_c;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [95:0] rd_c;
  logic        ready_a;
  logic        ready_b;
  logic        ready_c;

  always #5 clk = ~clk;

  regfile_param u_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_a),
    .we3(we3), .wa3(wa3), .wd3(wd3), .ra(ra_ab), .rd(rd_a)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_b),
    .we3(we3), .wa3(wa3), .wd3(wd3), .ra(ra_ab), .rd(rd_b)
  );

  regfile_param #(.NREGS(20), .NRD(3)) u_c (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_c),
    .we3(we3), .wa3(wa3), .wd3(wd3), .ra(ra_c), .rd(rd_c)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mwrite(input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
    if (we) begin
      if (wa != 5'd0) ma[wa] = wd;
      mb[wa] = wd;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    logic [31:0] w;
    int          n;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,
               32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 5'd6,  32'h12345678, 5'd5,  5'd6,
               32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd6,
               32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,
               32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,
               32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[5] = '{1'b1, 5'd0,  32'h00001111, 5'd0,  5'd6,
               32'h0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,
               32'h0, 32'hCAFEF00D, 32'h00001111, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30,
               32'hA5A5A5A5, 32'h0, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31,
               32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end

    // Reset and initial sweep
    rst_n   = 1'b0;
    clr_req = 1'b0;
    we3     = 1'b0;
    wa3     = '0;
    wd3     = '0;
    ra_ab   = {5'd2, 5'd1};
    ra_c    = {5'd3, 5'd2, 5'd1};
    #2;
    chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
    chk("rst_ready_c", {31'd0, ready_c}, 32'd0);
    chk("rst_rd_a0", rd_a[31:0], 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      we3 = 1'b1;
      wa3 = 5'd4;
      wd3 = 32'h55555555;
      #1;
      chk($sformatf("sweep_rd_a0_e%0d", e), rd_a[31:0], 32'd0);
      chk($sformatf("sweep_rd_b1_e%0d", e), rd_b[63:32], 32'd0);
      tick();
      chk($sformatf("sweep_ready_a_e%0d", e), {31'd0, ready_a},
          {31'd0, e == 32});
      chk($sformatf("sweep_ready_c_e%0d", e), {31'd0, ready_c},
          {31'd0, e >= 20});
    end
    we3 = 1'b0;
    for (int i = 1; i < 32; i++) begin
      ra_ab = {5'(i), 5'(i)};
      #1;
      chk($sformatf("post_rst_rd_a_%0d", i), rd_a[31:0], 32'd0);
      chk($sformatf("post_rst_rd_b_%0d", i), rd_b[63:32], 32'd0);
    end

    // Directed table: bypass, no-bypass, zero register
    for (int i = 0; i < 9; i++) begin
      we3   = tbl[i].we;
      wa3   = tbl[i].wa;
      wd3   = tbl[i].wd;
      ra_ab = {tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("tbl%0d_a0", i), rd_a[31:0],  tbl[i].a0);
      chk($sformatf("tbl%0d_a1", i), rd_a[63:32], tbl[i].a1);
      chk($sformatf("tbl%0d_b0", i), rd_b[31:0],  tbl[i].b0);
      chk($sformatf("tbl%0d_b1", i), rd_b[63:32], tbl[i].b1);
      mwrite(tbl[i].we, tbl[i].wa, tbl[i].wd);
      tick();
    end

    // Random write/readback on successive addresses
    prev = '0;
    for (int i = 1; i < 32; i++) begin
      w     = $urandom;
      we3   = 1'b1;
      wa3   = 5'(i);
      wd3   = w;
      ra_ab = {5'(i - 1), 5'(i)};
      #1;
      chk($sformatf("wb_b_same_%0d", i), rd_b[31:0], mb[i]);
      chk($sformatf("wb_a_byp_%0d", i), rd_a[31:0], w);
      if (i >= 2) begin
        chk($sformatf("wb_b_prev_%0d", i), rd_b[63:32], prev);
        chk($sformatf("wb_a_prev_%0d", i), rd_a[63:32], prev);
      end
      mwrite(1'b1, 5'(i), w);
      prev = w;
      tick();
    end
    we3   = 1'b0;
    ra_ab = {5'd31, 5'd31};
    #1;
    chk("wb_last_b0", rd_b[31:0], prev);
    chk("wb_last_b1", rd_b[63:32], prev);
    for (int i = 0; i < 32; i++) begin
      ra_ab = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("rb_a_%0d", i), rd_a[31:0], ma[i]);
      chk($sformatf("rb_b_%0d", i), rd_b[63:32], mb[31 - i]);
    end

    // Clear request coinciding with a write, plus a mid-sweep clr_req
    we3     = 1'b1;
    wa3     = 5'd3;
    wd3     = 32'h77777777;
    clr_req = 1'b1;
    ra_ab   = {5'd3, 5'd3};
    #1;
    chk("clr_byp_a", rd_a[31:0], 32'h77777777);
    chk("clr_ready_before", {31'd0, ready_a}, 32'd1);
    tick();
    clr_req = 1'b0;
    we3     = 1'b0;
    ra_ab   = {5'd7, 5'd3};
    for (int e = 1; e <= 32; e++) begin
      we3     = (e == 10);
      wa3     = 5'd7;
      wd3     = 32'h00001234;
      clr_req = (e == 10);
      #1;
      chk($sformatf("clr_ready_a_e%0d", e), {31'd0, ready_a}, 32'd0);
      chk($sformatf("clr_rd_a0_e%0d", e), rd_a[31:0], 32'd0);
      chk($sformatf("clr_rd_b1_e%0d", e), rd_b[63:32], 32'd0);
      tick();
      we3     = 1'b0;
      clr_req = 1'b0;
      if (e == 32) chk("clr_ready_a_end", {31'd0, ready_a}, 32'd1);
      if (e == 19 || e == 20)
        chk($sformatf("clr_ready_c_e%0d", e), {31'd0, ready_c},
            {31'd0, e == 20});
    end
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      ra_ab = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("clr_rb_a_%0d", i), rd_a[31:0], 32'd0);
      chk($sformatf("clr_rb_b_%0d", i), rd_b[63:32], 32'd0);
    end

    // Odd depth, three ports
    we3  = 1'b1;
    wa3  = 5'd19;
    wd3  = 32'h13131313;
    ra_c = {5'd0, 5'd19, 5'd19};
    #1;
    chk("c_byp_p0", rd_c[31:0],  32'h13131313);
    chk("c_byp_p1", rd_c[63:32], 32'h13131313);
    chk("c_byp_p2", rd_c[95:64], 32'd0);
    tick();
    wa3  = 5'd25;
    wd3  = 32'hBADBAD00;
    ra_c = {5'd0, 5'd19, 5'd25};
    #1;
    chk("c_oor_p0", rd_c[31:0],  32'd0);
    chk("c_oor_p1", rd_c[63:32], 32'h13131313);
    chk("c_oor_p2", rd_c[95:64], 32'd0);
    tick();
    we3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ra_c = {5'(i), 5'(i), 5'(i)};
      #1;
      chk($sformatf("c_rb_%0d", i), rd_c[63:32],
          (i == 19) ? 32'h13131313 : 32'd0);
    end
    ra_c = {5'd0, 5'd19, 5'd25};
    #1;
    chk("c_rd25", rd_c[31:0], 32'd0);

    // Reset asserted mid-sweep restarts a full sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    ra_ab = {5'd31, 5'd19};
    #1;
    chk("midrst_ready", {31'd0, ready_a}, 32'd0);
    chk("midrst_rd", rd_a[31:0], 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    while (!ready_a && n < 40) begin
      tick();
      n++;
    end
    chk("midrst_sweep_len", 32'(n), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
